// File: rtl/wb_pkg.sv
// Shared write-back definitions: FSM state encoding, load funct3 codes and the
// opcode constants the decoder uses to raise mem2reg / load_pc.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        COMMIT   = 2'd2
    } wb_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

endpackage

// File: rtl/writeback_ctrl_load_extend.sv
// Combinational sub-word load alignment: selects the addressed byte/half of an
// aligned memory word and sign- or zero-extends it according to funct3.
module load_extend (
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_word,
    output logic [31:0] o_data
);
    import wb_pkg::*;

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = '0;
        case (i_off)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        o_data = i_word;
        case (i_funct3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_data = {{16{w_half[15]}}, w_half};
            F3_LW:   o_data = i_word;
            F3_LBU:  o_data = {24'h0, w_byte};
            F3_LHU:  o_data = {16'h0, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/writeback_ctrl.sv
// Write-back stage: one register-file write per retiring instruction, stalling on loads.
// Optional load timeout enabled by defining WB_TIMEOUT_EN (adds MEM_TIMEOUT parameter).
module writeback_ctrl
`ifdef WB_TIMEOUT_EN
#(
    parameter int unsigned MEM_TIMEOUT = 16
)
`endif
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_alu,
    input  logic [31:0] in_pc,
    input  logic        in_mem2reg,
    input  logic        in_load_pc,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_en,
    output logic        wb_err
);
    import wb_pkg::*;

    wb_state_t   r_state;
    wb_state_t   w_state_nxt;
    logic [4:0]  r_rd;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic [31:0] r_data;
    logic [31:0] w_ext;
    logic        w_accept;
    logic        w_err;
    logic        w_timeout;

`ifdef WB_TIMEOUT_EN
    logic [7:0]  r_cnt;
    logic        r_err;

    assign w_timeout = (r_cnt == 8'(MEM_TIMEOUT - 1)) & ~mem_rvalid;
    assign w_err     = r_err;
`else
    assign w_timeout = 1'b0;
    assign w_err     = 1'b0;
`endif

    load_extend u_load_extend (
        .i_funct3 (r_funct3),
        .i_off    (r_off),
        .i_word   (mem_rdata),
        .o_data   (w_ext)
    );

    // Outputs decode straight from registered state so reset drops wb_en without a clock.
    assign in_ready = (r_state != WAIT_MEM);
    assign w_accept = in_valid & in_ready;
    assign wb_en    = (r_state == COMMIT) & (r_rd != 5'd0) & ~w_err;
    assign wb_err   = (r_state == COMMIT) & w_err;
    assign wb_data  = r_data;
    assign wb_rd    = r_rd;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, COMMIT: begin
                if (w_accept)
                    w_state_nxt = in_mem2reg ? WAIT_MEM : COMMIT;
                else
                    w_state_nxt = IDLE;
            end
            WAIT_MEM: begin
                if (mem_rvalid || w_timeout)
                    w_state_nxt = COMMIT;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd     <= '0;
            r_funct3 <= '0;
            r_off    <= '0;
            r_data   <= '0;
        end else if (w_accept) begin
            r_rd     <= in_rd;
            r_funct3 <= in_funct3;
            r_off    <= in_alu[1:0];
            // mem2reg wins over load_pc: load data replaces r_data later in WAIT_MEM
            if (!in_mem2reg)
                r_data <= in_load_pc ? (in_pc + 32'd4) : in_alu;
        end else if ((r_state == WAIT_MEM) && mem_rvalid) begin
            r_data <= w_ext;
        end
    end

`ifdef WB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (r_state == WAIT_MEM) begin
            if (w_timeout)
                r_err <= 1'b1;
            else if (!mem_rvalid)
                r_cnt <= r_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_writeback_ctrl.sv
// Directed, table-driven bench for writeback_ctrl (timeout case only when WB_TIMEOUT_EN is defined).
module tb_writeback_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu;
    logic [31:0] in_pc;
    logic        in_mem2reg;
    logic        in_load_pc;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_en;
    logic        wb_err;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    writeback_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd      (in_rd),
        .in_funct3  (in_funct3),
        .in_alu     (in_alu),
        .in_pc      (in_pc),
        .in_mem2reg (in_mem2reg),
        .in_load_pc (in_load_pc),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .wb_data    (wb_data),
        .wb_rd      (wb_rd),
        .wb_en      (wb_en),
        .wb_err     (wb_err)
    );

    typedef struct {
        string       name;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] pc;
        logic        mem2reg;
        logic        load_pc;
        logic [31:0] rdata;
        int          delay;
        logic        exp_en;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] pc, input logic m2r, input logic lpc);
        in_valid   = 1'b1;
        in_rd      = rd;
        in_funct3  = f3;
        in_alu     = alu;
        in_pc      = pc;
        in_mem2reg = m2r;
        in_load_pc = lpc;
    endtask

    // Called at a negedge with the stage in IDLE; returns at the negedge after COMMIT was checked.
    task automatic run_vec(input vec_t v);
        chk({v.name, " ready_before"}, 32'(in_ready), 32'd1);
        drive(v.rd, v.f3, v.alu, v.pc, v.mem2reg, v.load_pc);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        if (v.mem2reg) begin
            for (int i = 0; i < v.delay; i++) begin
                chk({v.name, " stall_ready"}, 32'(in_ready), 32'd0);
                chk({v.name, " stall_en"}, 32'(wb_en), 32'd0);
                mem_rvalid = (i == v.delay - 1);
                mem_rdata  = v.rdata;
                @(posedge clk);
                @(negedge clk);
            end
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
        end
        chk({v.name, " wb_en"}, 32'(wb_en), 32'(v.exp_en));
        chk({v.name, " wb_rd"}, 32'(wb_rd), 32'(v.rd));
        chk({v.name, " wb_data"}, wb_data, v.exp_data);
        chk({v.name, " ready_commit"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk({v.name, " en_after"}, 32'(wb_en), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{"alu_rd5",   5'd5,  3'd0, 32'h1234_5678, 32'h0,         1'b0, 1'b0, 32'h0,         0, 1'b1, 32'h1234_5678});
        vecs.push_back('{"jal_wrap",  5'd1,  3'd0, 32'h0,         32'hFFFF_FFFC, 1'b0, 1'b1, 32'h0,         0, 1'b1, 32'h0000_0000});
        vecs.push_back('{"jal_rd0",   5'd0,  3'd0, 32'h0,         32'hFFFF_FFFC, 1'b0, 1'b1, 32'h0,         0, 1'b0, 32'h0000_0000});
        vecs.push_back('{"jal_1000",  5'd31, 3'd0, 32'h5555_5555, 32'h0000_1000, 1'b0, 1'b1, 32'h0,         0, 1'b1, 32'h0000_1004});
        vecs.push_back('{"alu_rd0",   5'd0,  3'd0, 32'hFFFF_FFFF, 32'h0,         1'b0, 1'b0, 32'h0,         0, 1'b0, 32'hFFFF_FFFF});
        vecs.push_back('{"lb_off3",   5'd6,  3'b000, 32'h0000_0103, 32'h0,       1'b1, 1'b0, 32'h80FF_0000, 3, 1'b1, 32'hFFFF_FF80});
        vecs.push_back('{"lbu_off3",  5'd7,  3'b100, 32'h0000_0103, 32'h0,       1'b1, 1'b0, 32'h80FF_0000, 3, 1'b1, 32'h0000_0080});
        vecs.push_back('{"lhu_hi",    5'd8,  3'b101, 32'h0000_0202, 32'h0,       1'b1, 1'b0, 32'h80FF_0000, 3, 1'b1, 32'h0000_80FF});
        vecs.push_back('{"lh_hi",     5'd9,  3'b001, 32'h0000_0002, 32'h0,       1'b1, 1'b0, 32'h80FF_0000, 1, 1'b1, 32'hFFFF_80FF});
        vecs.push_back('{"lw",        5'd10, 3'b010, 32'h0000_0000, 32'h0,       1'b1, 1'b0, 32'h80FF_0000, 2, 1'b1, 32'h80FF_0000});
        vecs.push_back('{"lb_pos",    5'd11, 3'b000, 32'h0000_0000, 32'h0,       1'b1, 1'b0, 32'h1234_567F, 1, 1'b1, 32'h0000_007F});
        vecs.push_back('{"lb_off1",   5'd12, 3'b000, 32'h0000_0001, 32'h0,       1'b1, 1'b0, 32'h0000_8100, 1, 1'b1, 32'hFFFF_FF81});
        vecs.push_back('{"lhu_lo",    5'd13, 3'b101, 32'h0000_0000, 32'h0,       1'b1, 1'b0, 32'h1234_ABCD, 1, 1'b1, 32'h0000_ABCD});
        vecs.push_back('{"f3_011",    5'd14, 3'b011, 32'h0000_0003, 32'h0,       1'b1, 1'b0, 32'hCAFE_F00D, 2, 1'b1, 32'hCAFE_F00D});
        vecs.push_back('{"m2r_wins",  5'd15, 3'b010, 32'h0000_0000, 32'h0000_0100, 1'b1, 1'b1, 32'hDEAD_BEEF, 1, 1'b1, 32'hDEAD_BEEF});
        vecs.push_back('{"ld_rd0",    5'd0,  3'b010, 32'h0000_0000, 32'h0,       1'b1, 1'b0, 32'h7777_7777, 2, 1'b0, 32'h7777_7777});

        rst = 1'b1;
        in_valid = 1'b0; in_rd = '0; in_funct3 = '0; in_alu = '0; in_pc = '0;
        in_mem2reg = 1'b0; in_load_pc = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst wb_en", 32'(wb_en), 32'd0);
        chk("rst wb_data", wb_data, 32'd0);
        chk("rst wb_rd", 32'(wb_rd), 32'd0);
        chk("rst wb_err", 32'(wb_err), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // rvalid while idle must not produce a write
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("idle_rvalid wb_en", 32'(wb_en), 32'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // three ALU ops back to back
        drive(5'd2, 3'd0, 32'h0000_0A02, 32'h0, 1'b0, 1'b0);
        @(posedge clk); @(negedge clk);
        drive(5'd3, 3'd0, 32'h0000_0A03, 32'h0, 1'b0, 1'b0);
        chk("b2b0 en", 32'(wb_en), 32'd1);
        chk("b2b0 rd", 32'(wb_rd), 32'd2);
        chk("b2b0 data", wb_data, 32'h0000_0A02);
        chk("b2b0 ready", 32'(in_ready), 32'd1);
        @(posedge clk); @(negedge clk);
        drive(5'd4, 3'd0, 32'h0000_0A04, 32'h0, 1'b0, 1'b0);
        chk("b2b1 en", 32'(wb_en), 32'd1);
        chk("b2b1 rd", 32'(wb_rd), 32'd3);
        chk("b2b1 data", wb_data, 32'h0000_0A03);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        chk("b2b2 en", 32'(wb_en), 32'd1);
        chk("b2b2 rd", 32'(wb_rd), 32'd4);
        chk("b2b2 data", wb_data, 32'h0000_0A04);
        @(posedge clk); @(negedge clk);
        chk("b2b idle en", 32'(wb_en), 32'd0);
        chk("b2b hold data", wb_data, 32'h0000_0A04);

        // load followed by an ALU op that must stall until the load commits
        drive(5'd3, 3'b010, 32'h0, 32'h0, 1'b1, 1'b0);
        @(posedge clk); @(negedge clk);
        drive(5'd4, 3'd0, 32'h0000_AAAA, 32'h0, 1'b0, 1'b0);
        chk("ldalu stall0", 32'(in_ready), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("ldalu stall1", 32'(in_ready), 32'd0);
        chk("ldalu en_wait", 32'(wb_en), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0055;
        @(posedge clk); @(negedge clk);
        mem_rvalid = 1'b0;
        chk("ldalu ld_en", 32'(wb_en), 32'd1);
        chk("ldalu ld_rd", 32'(wb_rd), 32'd3);
        chk("ldalu ld_data", wb_data, 32'h0000_0055);
        chk("ldalu ready", 32'(in_ready), 32'd1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        chk("ldalu alu_en", 32'(wb_en), 32'd1);
        chk("ldalu alu_rd", 32'(wb_rd), 32'd4);
        chk("ldalu alu_data", wb_data, 32'h0000_AAAA);
        @(posedge clk); @(negedge clk);

        // reset while waiting on memory discards the load
        drive(5'd9, 3'b010, 32'h0, 32'h0, 1'b1, 1'b0);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        chk("rstw waiting", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("rstw ready_async", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
        @(posedge clk); @(negedge clk);
        mem_rvalid = 1'b0;
        chk("rstw no_write", 32'(wb_en), 32'd0);
        chk("rstw ready", 32'(in_ready), 32'd1);
        chk("rstw data_cleared", wb_data, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("rstw still_idle", 32'(wb_en), 32'd0);

        // reset during COMMIT drops wb_en without a clock edge
        drive(5'd20, 3'd0, 32'h0000_0BBB, 32'h0, 1'b0, 1'b0);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        chk("rstc en_before", 32'(wb_en), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstc en_async", 32'(wb_en), 32'd0);
        chk("rstc rd_async", 32'(wb_rd), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

`ifdef WB_TIMEOUT_EN
        drive(5'd17, 3'b010, 32'h0, 32'h0, 1'b1, 1'b0);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("tmo stall", 32'(in_ready), 32'd0);
            chk("tmo no_err", 32'(wb_err), 32'd0);
            @(posedge clk); @(negedge clk);
        end
        chk("tmo err", 32'(wb_err), 32'd1);
        chk("tmo en", 32'(wb_en), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("tmo err_clear", 32'(wb_err), 32'd0);
        chk("tmo ready", 32'(in_ready), 32'd1);
`else
        chk("noerr wb_err", 32'(wb_err), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
